// File: rtl/screen_line_fetcher.sv
// screen_line_fetcher: fetches one Hack screen row from SDRAM via ram_manager's
// command FIFO into a ping-pong line buffer; the VGA side reads the other bank.
// Optional build macro LINE_TIMEOUT_EN adds a per-line cycle watchdog.
module screen_line_fetcher #(
  parameter int unsigned SCREEN_BASE    = 16384,
  parameter int unsigned WORDS_PER_LINE = 32,
  parameter int unsigned TIMEOUT        = 4095
) (
  input  logic        clk100_0ds,
  input  logic        reset,
  input  logic        line_req,
  input  logic [7:0]  line_num,
  output logic [19:0] sdram_buffer_addr_in,
  output logic [15:0] sdram_buffer_data_in,
  output logic        sdram_buffer_rw_in,
  output logic        sdram_buffer_wrreq,
  input  logic        sdram_buffer_full,
  input  logic [15:0] data_output,
  input  logic [19:0] current_address,
  input  logic [4:0]  pix_word_addr,
  output logic [15:0] pix_word,
  output logic        line_busy,
  output logic        line_err
);

  localparam int unsigned    IW       = $clog2(WORDS_PER_LINE);
  localparam int unsigned    CW       = IW + 1;
  localparam logic [19:0]    BASE20   = 20'(SCREEN_BASE);
  localparam logic [19:0]    LAST_OFS = 20'(WORDS_PER_LINE - 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [19:0]   base_q, base_d;
  logic [19:0]   addr_q, addr_d;
  logic [19:0]   prev_q, prev_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          fill_bank_q, fill_bank_d;
  logic          err_q, err_d;
  logic [15:0]   pix_word_q, pix_word_d;
`ifdef LINE_TIMEOUT_EN
  localparam logic [11:0] TMO = 12'(TIMEOUT);
  logic [11:0]   tmo_q, tmo_d;
`endif

  logic [15:0]   line_mem [2*WORDS_PER_LINE];
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          push;
  logic          busy;
  logic          in_range;
  logic [19:0]   row_base;

  assign busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign in_range = (current_address >= base_q) && (current_address <= base_q + LAST_OFS);
  assign row_base = BASE20 + (20'(line_num) << IW);

  // Next-state, push generation, capture and line-start handling
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    addr_d      = addr_q;
    prev_d      = prev_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    fill_bank_d = fill_bank_q;
    err_d       = err_q;
    wr_en       = 1'b0;
    wr_idx      = current_address[IW-1:0];
    push        = 1'b0;
    pix_word_d  = line_mem[{~fill_bank_q, pix_word_addr[IW-1:0]}];
`ifdef LINE_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    unique case (state_q)
      ST_ISSUE: begin
        // Push is combinational on full so a full FIFO is never overrun;
        // reset and an incoming line_req both suppress it immediately.
        if (!sdram_buffer_full && !line_req && !reset) begin
          push        = 1'b1;
          issue_cnt_d = issue_cnt_q + CW'(1);
          if (issue_cnt_q == LAST_CNT) state_d = ST_WAIT;
          else                         addr_d  = addr_q + 20'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    // Any address change is tracked; only in-row changes are captured
    if (busy && (current_address != prev_q)) begin
      prev_d = current_address;
      if (in_range) begin
        wr_en    = 1'b1;
        rx_cnt_d = rx_cnt_q + CW'(1);
        if (rx_cnt_q == LAST_CNT) state_d = ST_DONE;
      end
    end

`ifdef LINE_TIMEOUT_EN
    if (busy) begin
      tmo_d = tmo_q + 12'd1;
      if ((tmo_d == TMO) && (state_d != ST_DONE)) begin
        err_d   = 1'b1;
        state_d = ST_DONE;
      end
    end
`endif

    // A new line overrides everything above, including a final capture
    if (line_req) begin
      if (busy) err_d = 1'b1;
      fill_bank_d = ~fill_bank_q;
      base_d      = row_base;
      addr_d      = row_base;
      prev_d      = current_address;
      issue_cnt_d = '0;
      rx_cnt_d    = '0;
      wr_en       = 1'b0;
      state_d     = ST_ISSUE;
`ifdef LINE_TIMEOUT_EN
      tmo_d       = '0;
`endif
    end
  end

  // Control and status registers
  always_ff @(posedge clk100_0ds) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      prev_q      <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      fill_bank_q <= 1'b0;
      err_q       <= 1'b0;
      pix_word_q  <= '0;
`ifdef LINE_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      prev_q      <= prev_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      fill_bank_q <= fill_bank_d;
      err_q       <= err_d;
      pix_word_q  <= pix_word_d;
`ifdef LINE_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Line buffer write port (contents are not reset)
  always_ff @(posedge clk100_0ds) begin
    if (wr_en && !reset) line_mem[{fill_bank_q, wr_idx}] <= data_output;
  end

  assign sdram_buffer_addr_in = addr_q;
  assign sdram_buffer_data_in = 16'h0000;
  assign sdram_buffer_rw_in   = 1'b0;
  assign sdram_buffer_wrreq   = push;
  assign pix_word             = pix_word_q;
  assign line_busy            = busy;
  assign line_err             = err_q;

endmodule
